// File: rtl/spectrum_x_mapper_pkg.sv
// Shared definitions for the spectrum pixel-column to FFT-bin mapper.
//   MAP_LINEAR / MAP_LOG : values of the mode input
//   ST_IDLE/BUILD/DONE   : edge-table build FSM encodings
//   sat_q / lin_step_q   : accumulator saturation and linear step in Q(BIN_W+1).FRAC_W
package spectrum_x_mapper_pkg;

  localparam logic MAP_LINEAR = 1'b0;
  localparam logic MAP_LOG    = 1'b1;

  typedef logic [1:0] build_state_t;

  localparam build_state_t ST_IDLE  = 2'd0;
  localparam build_state_t ST_BUILD = 2'd1;
  localparam build_state_t ST_DONE  = 2'd2;

  // NUM_BINS expressed in accumulator units: the largest edge value allowed.
  function automatic longint unsigned sat_q(input int unsigned bin_w,
                                            input int unsigned frac_w);
    return 64'd1 << (bin_w + frac_w);
  endfunction

  // Per-column increment of the linear-mode accumulator, truncated.
  function automatic longint unsigned lin_step_q(input int unsigned bin_w,
                                                 input int unsigned frac_w,
                                                 input int unsigned h_active);
    return sat_q(bin_w, frac_w) / 64'(h_active);
  endfunction

endpackage

// File: rtl/spectrum_x_mapper_edge_table.sv
// Column edge table: two simple dual-port RAMs with registered reads.
//   lo bank holds edge[k] at address k, hi bank holds edge[k] at address k-1,
//   so a single read address x returns edge[x] and edge[x+1] together.
// Ports:
//   clk_i                 clock
//   lo_we_i / lo_waddr_i  lo bank write enable / address
//   hi_we_i / hi_waddr_i  hi bank write enable / address
//   wdata_i               edge value written to either bank
//   raddr_i               lookup column
//   lo_rdata_o            edge[raddr] (one cycle after raddr)
//   hi_rdata_o            edge[raddr+1] (one cycle after raddr)
module x_edge_table #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk_i,
  input  logic              lo_we_i,
  input  logic [ADDR_W-1:0] lo_waddr_i,
  input  logic              hi_we_i,
  input  logic [ADDR_W-1:0] hi_waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] lo_rdata_o,
  output logic [DATA_W-1:0] hi_rdata_o
);

  logic [DATA_W-1:0] lo_mem [DEPTH];
  logic [DATA_W-1:0] hi_mem [DEPTH];

  // Read-before-write: a lookup issued in the same cycle as a rebuild write
  // sees the previous contents.
  always_ff @(posedge clk_i) begin
    if (lo_we_i) lo_mem[lo_waddr_i] <= wdata_i;
    lo_rdata_o <= lo_mem[raddr_i];
  end

  always_ff @(posedge clk_i) begin
    if (hi_we_i) hi_mem[hi_waddr_i] <= wdata_i;
    hi_rdata_o <= hi_mem[raddr_i];
  end

endmodule

// File: rtl/spectrum_x_mapper.sv
// Pixel-column to FFT-bin mapper with linear or logarithmic frequency axis.
// An internal FSM builds a per-column edge table after reset and whenever
// mode changes; lookups return the bin range [bin_lo, bin_hi] of a column
// with a fixed two-cycle latency.
// Ports:
//   clk          system/pixel clock
//   rst          asynchronous active-high reset
//   mode         0 = linear, 1 = log (level-sensitive)
//   pixel_x      current column
//   active       display-active qualifier
//   bin_index    same as bin_lo
//   bin_lo       first bin covered by the column
//   bin_hi       last bin covered by the column (>= bin_lo)
//   bin_valid    outputs meaningful
//   table_ready  edge table complete for the current mode
module spectrum_x_mapper
  import spectrum_x_mapper_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned PIX_W       = 10,
  parameter int unsigned BIN_W       = 9,
  parameter int unsigned FRAC_W      = 16,
  parameter int unsigned LOG_START_Q = 65536,
  parameter int unsigned LOG_RATIO_Q = 65936
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [PIX_W-1:0] pixel_x,
  input  logic             active,
  output logic [BIN_W-1:0] bin_index,
  output logic [BIN_W-1:0] bin_lo,
  output logic [BIN_W-1:0] bin_hi,
  output logic             bin_valid,
  output logic             table_ready
);

  localparam int unsigned NUM_BINS = 2 ** BIN_W;
  localparam int unsigned EDGE_W   = BIN_W + 1;
  localparam int unsigned ACC_W    = BIN_W + 1 + FRAC_W;
  localparam int unsigned PROD_W   = ACC_W + FRAC_W + 1;
  localparam int unsigned ADDR_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned K_W      = $clog2(H_ACTIVE + 1);

  localparam logic [ACC_W:0]    SAT_V       = (ACC_W+1)'(sat_q(BIN_W, FRAC_W));
  localparam logic [ACC_W:0]    STEP_V      = (ACC_W+1)'(lin_step_q(BIN_W, FRAC_W, H_ACTIVE));
  localparam logic [ACC_W-1:0]  LOG_START_V = ACC_W'(LOG_START_Q);
  localparam logic [PROD_W-1:0] RATIO_V     = PROD_W'(LOG_RATIO_Q);
  localparam logic [EDGE_W-1:0] EDGE_FULL   = EDGE_W'(NUM_BINS);
  localparam logic [EDGE_W-1:0] EDGE_MAX    = EDGE_W'(NUM_BINS - 1);
  localparam logic [K_W-1:0]    K_LAST      = K_W'(H_ACTIVE);
  localparam logic [PIX_W:0]    X_LIM       = (PIX_W+1)'(H_ACTIVE);

  // ---------------------------------------------------------------------
  // Build FSM and edge accumulator
  // ---------------------------------------------------------------------
  build_state_t      state_q, state_d;
  logic              mode_q, mode_d;
  logic              pend_q, pend_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ready_q, ready_d;

  logic              mode_chg;
  logic              start;
  logic [ACC_W:0]    lin_sum;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    log_shift;
  logic [ACC_W:0]    acc_step;
  logic [ACC_W-1:0]  acc_next;
  logic [EDGE_W-1:0] edge_wr;

  always_comb begin
    lin_sum   = {1'b0, acc_q} + STEP_V;
    prod      = PROD_W'(acc_q) * RATIO_V;
    log_shift = (ACC_W+1)'(prod >> FRAC_W);
    acc_step  = (mode_q == MAP_LOG) ? log_shift : lin_sum;
    // Saturating keeps every edge at or below NUM_BINS.
    if (acc_step > SAT_V) acc_step = SAT_V;
    acc_next  = ACC_W'(acc_step);
  end

  assign edge_wr  = (k_q == K_LAST) ? EDGE_FULL : acc_q[ACC_W-1:FRAC_W];
  assign mode_chg = (mode != mode_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    k_d     = k_q;
    acc_d   = acc_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE:  if (pend_q || mode_chg) start = 1'b1;
      ST_BUILD: begin
        if (mode_chg) begin
          start = 1'b1;
        end else if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d   = k_q + K_W'(1);
          acc_d = acc_next;
        end
      end
      ST_DONE:  if (mode_chg) start = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_BUILD;
      mode_d  = mode;
      pend_d  = 1'b0;
      k_d     = '0;
      acc_d   = (mode == MAP_LOG) ? LOG_START_V : '0;
    end
    ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MAP_LINEAR;
      pend_q  <= 1'b1;
      k_q     <= '0;
      acc_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      ready_q <= ready_d;
    end
  end

  // ---------------------------------------------------------------------
  // Edge table
  // ---------------------------------------------------------------------
  logic              build_wr;
  logic              lo_we, hi_we;
  logic [ADDR_W-1:0] lo_waddr, hi_waddr;
  logic              in_range;
  logic [ADDR_W-1:0] raddr;
  logic [EDGE_W-1:0] lo_rd, hi_rd;

  assign build_wr = (state_q == ST_BUILD);
  assign lo_we    = build_wr && (k_q != K_LAST);
  assign hi_we    = build_wr && (k_q != '0);
  assign lo_waddr = ADDR_W'(k_q);
  assign hi_waddr = ADDR_W'(k_q - K_W'(1));

  assign in_range = ({1'b0, pixel_x} < X_LIM);
  assign raddr    = in_range ? ADDR_W'(pixel_x) : '0;

  x_edge_table #(
    .DEPTH  (H_ACTIVE),
    .ADDR_W (ADDR_W),
    .DATA_W (EDGE_W)
  ) u_table (
    .clk_i      (clk),
    .lo_we_i    (lo_we),
    .lo_waddr_i (lo_waddr),
    .hi_we_i    (hi_we),
    .hi_waddr_i (hi_waddr),
    .wdata_i    (edge_wr),
    .raddr_i    (raddr),
    .lo_rdata_o (lo_rd),
    .hi_rdata_o (hi_rd)
  );

  // ---------------------------------------------------------------------
  // Lookup pipeline: stage 1 samples the qualifier alongside the RAM read,
  // stage 2 turns the two edges into a clipped bin range.
  // ---------------------------------------------------------------------
  logic              vld_s1_q;
  logic              vld_s1_d;
  logic [EDGE_W-1:0] hi_full;
  logic [EDGE_W-1:0] lo_clip, hi_clip;
  logic [BIN_W-1:0]  lo_d, hi_d;
  logic [BIN_W-1:0]  lo_q, hi_q;
  logic              vld_q;

  assign vld_s1_d = active && in_range && ready_q;

  always_comb begin
    hi_full = (hi_rd > lo_rd) ? (hi_rd - EDGE_W'(1)) : lo_rd;
    lo_clip = (lo_rd > EDGE_MAX) ? EDGE_MAX : lo_rd;
    hi_clip = (hi_full > EDGE_MAX) ? EDGE_MAX : hi_full;
    lo_d    = '0;
    hi_d    = '0;
    if (vld_s1_q) begin
      lo_d = BIN_W'(lo_clip);
      hi_d = BIN_W'(hi_clip);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_s1_q <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      vld_q    <= 1'b0;
    end else begin
      vld_s1_q <= vld_s1_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      vld_q    <= vld_s1_q;
    end
  end

  assign bin_lo      = lo_q;
  assign bin_index   = lo_q;
  assign bin_hi      = hi_q;
  assign bin_valid   = vld_q;
  assign table_ready = ready_q;

endmodule
